// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, LSB-first data, optional parity, stop bits.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 baud_tick,
    output logic                 baud_en,
    output logic                 txd,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [CW-1:0]        r_cnt;
    logic                 r_txd;
    logic                 r_baud_en;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_in_ready;

`ifdef UART_TX_PARITY_EN
    logic                 r_par;
    logic                 w_par;

    // Parity of the byte being accepted, inverted for odd parity
    assign w_par = (^in_data) ^ PARITY_ODD;
`else
    logic                 w_unused_parity_odd;

    assign w_unused_parity_odd = PARITY_ODD;
`endif

    // Frame sequencer with every output held in a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_txd      <= 1'b1;
            r_baud_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_in_ready <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_txd      <= 1'b1;
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_shift    <= in_data;
                        r_cnt      <= '0;
                        r_state    <= S_START;
                        r_txd      <= 1'b0;
                        r_baud_en  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        r_par      <= w_par;
`endif
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        r_state <= S_DATA;
                        r_txd   <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        r_shift <= r_shift >> 1;
                        if (r_cnt == LAST_DATA) begin
                            r_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_txd   <= r_par;
`else
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            r_txd <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_tick) begin
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
`endif
                S_STOP: begin
                    r_txd <= 1'b1;
                    if (baud_tick) begin
                        if (r_cnt == LAST_STOP) begin
                            r_state   <= S_IDLE;
                            r_cnt     <= '0;
                            r_done    <= 1'b1;
                            r_baud_en <= 1'b0;
                            r_busy    <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign baud_en  = r_baud_en;
    assign txd      = r_txd;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: two instances (8N1 even, 7-bit 2-stop odd).
// Honours UART_TX_PARITY_EN for the expected frame layout.
module tb_uart_tx_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v0, rdy0, be0, tx0, bz0, dn0, tk0, x0;
    logic [7:0] d0;
    logic       v1, rdy1, be1, tx1, bz1, dn1, tk1, x1;
    logic [6:0] d1;
    int         c0 = 0, c1 = 0;
    int         nd0 = 0, nd1 = 0;
    int         total = 0, bad = 0;

    uart_tx_serializer #(
        .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1'b0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0),
        .in_data(d0), .baud_tick(tk0), .baud_en(be0), .txd(tx0),
        .busy(bz0), .done(dn0)
    );

    uart_tx_serializer #(
        .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
        .in_data(d1), .baud_tick(tk1), .baud_en(be1), .txd(tx1),
        .busy(bz1), .done(dn1)
    );

    // Tick model: one pulse every 16 clks while enabled, phase reset when disabled
    always_ff @(posedge clk) begin
        c0 <= be0 ? ((c0 == 15) ? 0 : c0 + 1) : 0;
        c1 <= be1 ? ((c1 == 15) ? 0 : c1 + 1) : 0;
        if (dn0) nd0 <= nd0 + 1;
        if (dn1) nd1 <= nd1 + 1;
    end

    assign tk0 = (be0 && c0 == 15) || x0;
    assign tk1 = (be1 && c1 == 15) || x1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller has offered a byte at a negedge with in_ready high.
    // Checks the whole frame, ends one negedge after the done cycle.
    task automatic frame(input bit s, input logic [8:0] d, input bit nv,
                         input logic [8:0] ndat, input bit scr,
                         input string tag);
        int   nd;
        int   ns;
        int   base;
        bit   po;
        logic xb[$];
        nd   = s ? 7 : 8;
        ns   = s ? 2 : 1;
        po   = s;
        base = s ? nd1 : nd0;
        xb.push_back(1'b0);
        for (int i = 0; i < nd; i++) xb.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        xb.push_back((^d) ^ po);
`endif
        for (int i = 0; i < ns; i++) xb.push_back(1'b1);
        @(negedge clk);
        chk({tag, " start_txd"}, s ? tx1 : tx0, 0);
        chk({tag, " start_busy"}, s ? bz1 : bz0, 1);
        chk({tag, " start_en"}, s ? be1 : be0, 1);
        chk({tag, " start_rdy"}, s ? rdy1 : rdy0, 0);
        if (s) begin v1 = nv; d1 = ndat[6:0]; end
        else   begin v0 = nv; d0 = ndat[7:0]; end
        for (int k = 0; k < xb.size(); k++) begin
            repeat ((k == 0) ? 8 : 16) @(negedge clk);
            if (scr) begin
                if (s) d1 = 7'($urandom);
                else   d0 = 8'($urandom);
            end
            chk($sformatf("%s bit%0d", tag, k), s ? tx1 : tx0, 32'(xb[k]));
            chk($sformatf("%s nodone%0d", tag, k), s ? dn1 : dn0, 0);
        end
        repeat (8) @(negedge clk);
        chk({tag, " done"}, s ? dn1 : dn0, 1);
        chk({tag, " end_busy"}, s ? bz1 : bz0, 0);
        chk({tag, " end_en"}, s ? be1 : be0, 0);
        chk({tag, " end_txd"}, s ? tx1 : tx0, 1);
        @(negedge clk);
        chk({tag, " done_off"}, s ? dn1 : dn0, 0);
        chk({tag, " rdy_after"}, s ? rdy1 : rdy0, 1);
        chk({tag, " gap_txd"}, s ? tx1 : tx0, 1);
        chk({tag, " ndone"}, s ? nd1 : nd0, base + 1);
    endtask

    initial begin
        #3000000;
        $error("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int snap;
        rst_n = 1'b0;
        v0 = 0; d0 = 0; x0 = 0;
        v1 = 0; d1 = 0; x1 = 0;
        repeat (2) @(negedge clk);
        chk("rst_txd", tx0, 1);
        chk("rst_en", be0, 0);
        chk("rst_busy", bz0, 0);
        chk("rst_done", dn0, 0);
        chk("rst_rdy", rdy0, 1);
        rst_n = 1'b1;
        @(negedge clk);

        v0 = 1; d0 = 8'h55;
        frame(0, 9'h055, 0, 9'h000, 0, "f55");

        v0 = 1; d0 = 8'hA3;
        frame(0, 9'h0A3, 1, 9'h00F, 0, "fA3");
        frame(0, 9'h00F, 0, 9'h000, 0, "f0F");
        chk("b2b_count", nd0, 3);

        @(negedge clk);
        v0 = 1; d0 = 8'h07;
        frame(0, 9'h007, 0, 9'h000, 0, "f07");

        v1 = 1; d1 = 7'h7F;
        frame(1, 9'h07F, 0, 9'h000, 0, "s7F");
        v1 = 1; d1 = 7'h07;
        frame(1, 9'h007, 0, 9'h000, 0, "s07");

        v0 = 1; d0 = 8'h00;
        @(negedge clk);
        v0 = 0;
        repeat (8 + 16 * 4) @(negedge clk);
        chk("abort_pre_txd", tx0, 0);
        chk("abort_pre_busy", bz0, 1);
        snap = nd0;
        #1 rst_n = 1'b0;
        #1;
        chk("abort_txd", tx0, 1);
        chk("abort_busy", bz0, 0);
        chk("abort_en", be0, 0);
        chk("abort_done", dn0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_nodone", nd0, snap);
        chk("abort_idle_txd", tx0, 1);
        chk("abort_rdy", rdy0, 1);
        v0 = 1; d0 = 8'h3C;
        frame(0, 9'h03C, 0, 9'h000, 0, "f3C");

        for (int i = 0; i < 5; i++) begin
            x0 = 1;
            @(negedge clk);
            x0 = 0;
            @(negedge clk);
            chk($sformatf("idle_busy%0d", i), bz0, 0);
            chk($sformatf("idle_txd%0d", i), tx0, 1);
            chk($sformatf("idle_en%0d", i), be0, 0);
        end
        v0 = 1; d0 = 8'hC6;
        frame(0, 9'h0C6, 0, 9'h000, 1, "fC6");
        chk("final_count", nd0, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
